// File: rtl/dual_mode_multiplier_if.sv
// Operation bus for dual_mode_multiplier.
//   in_valid   : operation (a, b, signed_mul) presented this cycle
//   a, b       : N-bit operands
//   signed_mul : 1 = two's-complement operands, 0 = unsigned
//   out_valid  : res carries a new product this cycle
//   res        : 2N-bit product
// master drives operations (requester), slave is the multiplier.
interface dual_mode_multiplier_if #(
    parameter int N = 4
);
    logic             in_valid;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             signed_mul;
    logic             out_valid;
    logic [2*N-1:0]   res;

    modport master (output in_valid, a, b, signed_mul, input out_valid, res);
    modport slave  (input in_valid, a, b, signed_mul, output out_valid, res);
endinterface

// File: rtl/dual_mode_multiplier.sv
// Pipelined N x N multiplier with per-operation signed/unsigned mode.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : operation bus (slave side), see dual_mode_multiplier_if
// Both operands are widened to N+1 bits with (MSB & signed_mul) as the
// extension bit, so one signed (N+1)x(N+1) shift-add array serves both
// modes; the low 2N bits of its product are the result.
// Stage 1 registers the N+1 partial-product rows, stage 2 sums them and
// any further stages just delay the product. With LATENCY = 1 the rows
// are generated and summed in the single stage.
module dual_mode_multiplier #(
    parameter int N       = 4,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dual_mode_multiplier_if.slave bus
);
    localparam int M = N + 1;   // extended operand width / row count
    localparam int P = 2 * N;   // product width
    localparam logic [P-1:0] ONE = P'(1);

    // ---------------- operand extension and partial products ----------
    logic [M-1:0]          ea, eb;
    logic [P-1:0]          ea_x;
    logic [M-1:0][P-1:0]   pp;

    assign ea   = {bus.a[N-1] & bus.signed_mul, bus.a};
    assign eb   = {bus.b[N-1] & bus.signed_mul, bus.b};
    assign ea_x = {{(P-M){ea[M-1]}}, ea};

    // Rows 0..N-1 are positive-weight bits of eb. Row N is eb's sign bit,
    // whose weight is -2^N, so that row is negated. All rows mod 2^P.
    always_comb begin
        for (int i = 0; i < N; i++)
            pp[i] = eb[i] ? (ea_x << i) : '0;
        pp[N] = eb[N] ? (ONE + ~(ea_x << N)) : '0;
    end

    function automatic logic [P-1:0] add_rows(input logic [M-1:0][P-1:0] rows);
        logic [P-1:0] acc;
        acc = '0;
        for (int i = 0; i < M; i++)
            acc = acc + rows[i];
        return acc;
    endfunction

    // ---------------- valid pipeline ----------------------------------
    // vld_pipe[k] is high when stage k holds a live operation.
    logic [LATENCY:1] vld_q;
    logic [LATENCY:0] vld_pipe;

    assign vld_pipe = {vld_q, bus.in_valid};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= vld_pipe[LATENCY-1:0];
    end

    // ---------------- data pipeline -----------------------------------
    // Each stage loads only when its input stage is valid, which keeps
    // res stable between results and blocks idle-cycle data.
    logic [P-1:0] res_q;

    if (LATENCY == 1) begin : g_lat1
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)           res_q <= '0;
            else if (vld_pipe[0]) res_q <= add_rows(pp);
        end
    end else begin : g_latn
        logic [M-1:0][P-1:0]     pp_q;
        logic [LATENCY:2][P-1:0] prod_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pp_q   <= '0;
                prod_q <= '0;
            end else begin
                if (vld_pipe[0]) pp_q      <= pp;
                if (vld_pipe[1]) prod_q[2] <= add_rows(pp_q);
                for (int k = 3; k <= LATENCY; k++)
                    if (vld_pipe[k-1]) prod_q[k] <= prod_q[k-1];
            end
        end

        assign res_q = prod_q[LATENCY];
    end

    assign bus.out_valid = vld_pipe[LATENCY];
    assign bus.res       = res_q;

endmodule

// File: tb/tb_dual_mode_multiplier.sv
module tb_dual_mode_multiplier;
    localparam int L = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dual_mode_multiplier_if #(.N(4)) bus4  ();
    dual_mode_multiplier_if #(.N(8)) bus8a ();
    dual_mode_multiplier_if #(.N(8)) bus8b ();

    dual_mode_multiplier #(.N(4), .LATENCY(2)) dut     (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    dual_mode_multiplier #(.N(8), .LATENCY(1)) u_n8_l1 (.clk(clk), .rst_n(rst_n), .bus(bus8a.slave));
    dual_mode_multiplier #(.N(8), .LATENCY(4)) u_n8_l4 (.clk(clk), .rst_n(rst_n), .bus(bus8b.slave));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       s;
        logic [7:0] exp;
    } vec4_t;

    typedef struct {
        int         due;
        logic [7:0] exp;
    } pend_t;

    pend_t      q[$];
    logic [7:0] last_res = '0;
    bit         chk_en   = 1'b0;

    // Every cycle: either the expected result is due now, or out_valid
    // must be low and res must hold the previous result.
    always @(negedge clk) begin
        if (chk_en) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("out_valid", 32'(bus4.out_valid), 32'd1);
                chk("res", 32'(bus4.res), 32'(q[0].exp));
                last_res = q[0].exp;
                void'(q.pop_front());
            end else begin
                chk("out_valid_idle", 32'(bus4.out_valid), 32'd0);
                chk("res_hold", 32'(bus4.res), 32'(last_res));
            end
        end
    end

    function automatic logic [7:0] m4(input logic [3:0] a, input logic [3:0] b, input logic s);
        int sa, sb;
        sa = s ? int'($signed(a)) : int'(a);
        sb = s ? int'($signed(b)) : int'(b);
        return 8'(sa * sb);
    endfunction

    function automatic logic [15:0] m8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int sa, sb;
        sa = s ? int'($signed(a)) : int'(a);
        sb = s ? int'($signed(b)) : int'(b);
        return 16'(sa * sb);
    endfunction

    task automatic drive4(input bit v, input logic [3:0] a, input logic [3:0] b,
                          input logic s, input logic [7:0] exp);
        pend_t p;
        @(posedge clk); #1;
        bus4.in_valid   = v;
        bus4.a          = a;
        bus4.b          = b;
        bus4.signed_mul = s;
        if (v) begin
            p.due = cyc + L;
            p.exp = exp;
            q.push_back(p);
        end
    endtask

    task automatic idle4();
        drive4(1'b0, 4'($urandom), 4'($urandom), 1'($urandom), 8'h00);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] exp);
        @(posedge clk); #1;
        bus8a.in_valid = 1'b1; bus8a.a = a; bus8a.b = b; bus8a.signed_mul = s;
        bus8b.in_valid = 1'b1; bus8b.a = a; bus8b.b = b; bus8b.signed_mul = s;
        @(posedge clk); #1;
        bus8a.in_valid = 1'b0; bus8a.a = 8'($urandom); bus8a.b = 8'($urandom);
        bus8b.in_valid = 1'b0; bus8b.a = 8'($urandom); bus8b.b = 8'($urandom);
        @(negedge clk);
        chk("n8l1_out_valid", 32'(bus8a.out_valid), 32'd1);
        chk("n8l1_res", 32'(bus8a.res), 32'(exp));
        chk("n8l4_out_valid_early", 32'(bus8b.out_valid), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("n8l4_out_valid", 32'(bus8b.out_valid), 32'd1);
        chk("n8l4_res", 32'(bus8b.res), 32'(exp));
        chk("n8l1_out_valid_after", 32'(bus8a.out_valid), 32'd0);
        chk("n8l1_res_hold", 32'(bus8a.res), 32'(exp));
    endtask

    vec4_t tbl[12];

    initial begin
        tbl = '{
            '{4'hF, 4'hF, 1'b0, 8'hE1},   // mode alternation: 0, 1, 0
            '{4'hF, 4'hF, 1'b1, 8'h01},
            '{4'hF, 4'hF, 1'b0, 8'hE1},
            '{4'h0, 4'hF, 1'b0, 8'h00},
            '{4'h8, 4'h8, 1'b1, 8'h40},   // -8 * -8 = +64
            '{4'h8, 4'h7, 1'b1, 8'hC8},   // -8 * 7 = -56
            '{4'h7, 4'h7, 1'b1, 8'h31},
            '{4'hF, 4'h7, 1'b1, 8'hF9},   // -1 * 7
            '{4'h8, 4'h8, 1'b0, 8'h40},   // 8 * 8 = 64
            '{4'h7, 4'h3, 1'b0, 8'h15},
            '{4'h9, 4'h3, 1'b1, 8'hEB},   // -7 * 3 = -21
            '{4'h0, 4'h8, 1'b1, 8'h00}
        };

        bus4.in_valid  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.signed_mul  = 1'b0;
        bus8a.in_valid = 1'b0; bus8a.a = '0; bus8a.b = '0; bus8a.signed_mul = 1'b0;
        bus8b.in_valid = 1'b0; bus8b.a = '0; bus8b.b = '0; bus8b.signed_mul = 1'b0;

        // reset state
        #12;
        chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("rst_res", 32'(bus4.res), 32'd0);
        chk("rst_n8l1_out_valid", 32'(bus8a.out_valid), 32'd0);
        chk("rst_n8l4_res", 32'(bus8b.res), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk_en = 1'b1;

        // directed table, back-to-back
        foreach (tbl[i]) drive4(1'b1, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp);

        // bubbles 1,0,1,1,0 with junk data in idle slots
        drive4(1'b1, 4'h2, 4'h3, 1'b0, 8'h06);
        idle4();
        drive4(1'b1, 4'h5, 4'h5, 1'b0, 8'h19);
        drive4(1'b1, 4'hF, 4'h8, 1'b1, 8'h08);   // -1 * -8
        idle4();

        // exhaustive unsigned then signed, streamed
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 256; i++)
                drive4(1'b1, 4'(i >> 4), 4'(i), 1'(s), m4(4'(i >> 4), 4'(i), 1'(s)));
        repeat (L + 2) idle4();

        // reset mid-stream: first op is on the output, two more in flight
        drive4(1'b1, 4'h1, 4'h1, 1'b0, 8'h01);
        drive4(1'b1, 4'h2, 4'h2, 1'b0, 8'h04);
        drive4(1'b1, 4'h3, 4'h3, 1'b0, 8'h09);
        #2;
        chk_en = 1'b0;
        chk("pre_rst_out_valid", 32'(bus4.out_valid), 32'd1);
        rst_n = 1'b0;
        bus4.in_valid = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("async_rst_res", 32'(bus4.res), 32'd0);
        q.delete();
        @(posedge clk); #1;
        chk("in_rst_out_valid", 32'(bus4.out_valid), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        last_res = '0;
        #1 chk_en = 1'b1;
        repeat (4) idle4();
        drive4(1'b1, 4'h3, 4'h5, 1'b0, 8'h0F);
        repeat (L + 2) idle4();
        chk("queue_drained", 32'(q.size()), 32'd0);

        // N = 8, LATENCY = 1 and 4
        op8(8'h80, 8'h80, 1'b1, 16'h4000);
        op8(8'h80, 8'h80, 1'b0, 16'h4000);
        op8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        op8(8'hFF, 8'hFF, 1'b1, 16'h0001);
        op8(8'h7F, 8'h80, 1'b1, 16'hC080);
        op8(8'h7F, 8'h7F, 1'b0, 16'h3F01);
        op8(8'h12, 8'h34, 1'b0, 16'h03A8);
        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra, rb;
            logic       rs;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            op8(ra, rb, rs, m8(ra, rb, rs));
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dual_mode_multiplier.md
Name: dual_mode_multiplier

Overview:
- Pipelined N x N integer multiplier. A per-operation mode bit selects unsigned or two's-complement signed interpretation of both operands.
- Produces the full 2N-bit product with fixed latency, at a throughput of one operation per clock.
- Used as a shared arithmetic unit wherever both signed and unsigned products are needed, so no separate signed and unsigned multipliers are required.

Parameters:
- N, 4, operand width in bits; legal N >= 2.
- LATENCY, 2, clock cycles from input accept to result valid; legal values 1..4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  a, b and signed_mul are valid this cycle and are accepted.
- a  input  N  multiplicand.
- b  input  N  multiplier.
- signed_mul  input  1  1 = treat a and b as two's-complement signed; 0 = treat them as unsigned.
- out_valid  output  1  res holds a new product this cycle.
- res  output  2N  product; two's-complement when the operation was signed, zero-extended magnitude when unsigned.

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset:
  - While rst_n = 0: out_valid = 0, res = 0, and all internal valid bits are cleared.
  - Reset release is synchronous to clk.
  - Asserting reset mid-operation discards all in-flight operations; no out_valid pulses follow for them.
- Handshake:
  - No backpressure; every cycle with in_valid = 1 accepts one operation.
  - Exactly LATENCY cycles later, out_valid = 1 for one cycle with that operation's result.
  - Back-to-back inputs yield back-to-back outputs, in order.
- Mode:
  - signed_mul is captured with its operands and travels with them through the pipeline.
  - Mixed signed and unsigned operations in consecutive cycles are legal and independent.
- Arithmetic:
  - Unsigned: res = a * b, with 0 <= res <= (2^N - 1)^2. Never overflows 2N bits.
  - Signed: res = sa * sb in 2N-bit two's complement, where sa and sb are the sign-interpreted a and b. The range -2^(N-1) * (2^(N-1) - 1) to 2^(2N-2) always fits 2N bits.
  - Corner case smin * smin = +2^(2N-2) must be positive (e.g. N = 4: -8 * -8 = +64, i.e. 8'h40).
  - Implementation: a single shared datapath. Extend each operand to N+1 bits, using (MSB AND signed_mul) as the extension bit. Form the signed (N+1) x (N+1) product and keep its low 2N bits. Separate signed and unsigned arrays are not permitted.
  - Partial-product generation goes in stage 1; summation completes by the final stage. The datapath is a shift-add array of N+1 rows, not a vendor multiplier primitive.
- Output holding:
  - res changes only in cycles where out_valid = 1 and holds its last value otherwise.
  - res is fully registered; no combinational path from any input to res or out_valid.
- No X propagation: when in_valid = 0, the input data values must not affect res or out_valid.

Test Plan:
- Exhaustive unsigned, N = 4: all 256 (a, b) pairs with signed_mul = 0, streamed back-to-back. Each res = a * b after exactly LATENCY cycles (e.g. 15 * 15 -> 8'hE1 = 225; 0 * 15 -> 0).
- Exhaustive signed, N = 4: all pairs a, b in -8..7 with signed_mul = 1. Each res = sa * sb (e.g. -8 * -8 -> 8'h40; -8 * 7 -> 8'hC8 = -56; 7 * 7 -> 8'h31 = 49; -1 * 7 -> 8'hF9).
- Mode alternation: a = 4'hF, b = 4'hF on consecutive cycles with signed_mul 0, 1, 0. Outputs in order are 8'hE1, 8'h01, 8'hE1.
- Bubbles: in_valid pattern 1,0,1,1,0. out_valid reproduces the same pattern delayed by LATENCY, and res holds its value during bubble cycles.
- Reset mid-stream: issue 3 operations, then pull rst_n low asynchronously between edges. out_valid and res go to 0 immediately, no stale results appear after release, and the next operation (3 * 5, unsigned) returns 8'h0F.
- Parameter sweep: N = 8 and LATENCY = 1 / 4, with random signed/unsigned operands including 8'h80 * 8'h80. Signed gives 16'h4000, unsigned gives 16'h4000; 8'hFF * 8'hFF gives 16'hFE01 unsigned and 16'h0001 signed.
